// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and stall control for a 5-stage in-order pipeline.
// This block handles three kinds of hazard:
//   - RAW hazards: stalls IF/ID and inserts a bubble into ID/EX.
//   - Taken branches: flushes the two younger stages.
//   - Multi-cycle MDU ops: freezes the front end for MDU_LAT cycles.
// Optional build macro: HAZ_FORWARD_EN.
//   - When defined, MEM/WB -> EX forwarding is compiled in, and only load-use
//     dependences stall.
//   - When undefined, forwarding selects stay 00, and both EX and MEM
//     producers stall.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [1:0] id_use,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  input  logic       branch_taken,
  input  logic       mdu_start,
  output logic       pc_en_bar,
  output logic       ifid_en_bar,
  output logic       idex_en_bar,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       busy
);

  typedef enum logic {RUN = 1'b0, MDU_BUSY = 1'b1} state_t;

  localparam logic [3:0] LAT = 4'(MDU_LAT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // An ID source only takes part in hazard checks when it is actually read
  // and is not r0, so a write to r0 never creates a dependence.
  logic use_rs, use_rt;
  assign use_rs = id_use[0] & (id_rs != 5'd0);
  assign use_rt = id_use[1] & (id_rt != 5'd0);

  logic raw_stall;
  logic [1:0] fwd_a, fwd_b;

`ifdef HAZ_FORWARD_EN
  // Forwarding build.
  //   - Only a load in EX cannot be bypassed, so it costs one bubble.
  //   - For a source, the youngest producer wins: MEM has priority over WB.
  always_comb begin
    raw_stall = ex_mem_read & ex_reg_write &
                ((use_rs & (id_rs == ex_rd)) | (use_rt & (id_rt == ex_rd)));
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs)    fwd_a = 2'b10;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs)  fwd_a = 2'b01;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rt)    fwd_b = 2'b10;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rt)  fwd_b = 2'b01;
  end
`else
  // No-bypass build.
  //   - Any pending write in EX or MEM to a source register stalls.
  //   - A write in WB lands before the regfile read, so WB never stalls.
  always_comb begin
    raw_stall = (ex_reg_write &
                 ((use_rs & (id_rs == ex_rd)) | (use_rt & (id_rt == ex_rd)))) |
                (mem_reg_write &
                 ((use_rs & (id_rs == mem_rd)) | (use_rt & (id_rt == mem_rd))));
    fwd_a = 2'b00;
    fwd_b = 2'b00;
  end
`endif

  // State and MDU countdown registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  //   - A taken branch squashes a coincident mdu_start.
  //   - Once busy, every other request is ignored until the count hits 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mdu_start && !branch_taken) begin
          state_d = MDU_BUSY;
          cnt_d   = LAT;
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output decode, in priority order: reset, MDU busy, branch, RAW, normal.
  always_comb begin
    pc_en_bar   = 1'b0;
    ifid_en_bar = 1'b0;
    idex_en_bar = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fwd_a_sel   = fwd_a;
    fwd_b_sel   = fwd_b;
    busy        = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      fwd_a_sel   = 2'b00;
      fwd_b_sel   = 2'b00;
    end else if (state_q == MDU_BUSY) begin
      pc_en_bar   = 1'b1;
      ifid_en_bar = 1'b1;
      idex_en_bar = 1'b1;
      exmem_flush = 1'b1;
      busy        = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (raw_stall) begin
      pc_en_bar   = 1'b1;
      ifid_en_bar = 1'b1;
      idex_flush  = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Each step drives inputs just after a rising edge and queues the expected
// output vector. The vector is popped and compared at the following falling
// edge.
// Vector layout, MSB first:
//   pc_en_bar, ifid_en_bar, idex_en_bar, ifid_flush, idex_flush, exmem_flush,
//   fwd_a_sel[1:0], fwd_b_sel[1:0], busy.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic [1:0] id_use;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
  logic       branch_taken, mdu_start;
  logic       pc_en_bar, ifid_en_bar, idex_en_bar;
  logic       ifid_flush, idex_flush, exmem_flush, busy;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;

  exp_t sb[$];

  pipe_hazard_ctrl #(.MDU_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use(id_use),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .mdu_start(mdu_start),
    .pc_en_bar(pc_en_bar), .ifid_en_bar(ifid_en_bar), .idex_en_bar(idex_en_bar),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  // Canonical expected vectors.
  localparam logic [10:0] NORM  = 11'b000_000_00_00_0;
  localparam logic [10:0] RSTV  = 11'b000_111_00_00_0;
  localparam logic [10:0] RAW   = 11'b110_010_00_00_0;
  localparam logic [10:0] BRCH  = 11'b000_110_00_00_0;
  localparam logic [10:0] MDUB  = 11'b111_001_00_00_1;

`ifdef HAZ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic clear_inputs();
    rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use = 2'b00;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0; wb_rd = 5'd0; wb_reg_write = 1'b0;
    branch_taken = 1'b0; mdu_start = 1'b0;
  endtask

  // Queue the expectation for the inputs currently driven, compare at the
  // falling edge, then advance to just past the next rising edge.
  task automatic step(input string tag, input logic [10:0] e);
    exp_t x;
    logic [10:0] obs;
    sb.push_back('{tag, e});
    @(negedge clk);
    obs = {pc_en_bar, ifid_en_bar, idex_en_bar, ifid_flush, idex_flush,
           exmem_flush, fwd_a_sel, fwd_b_sel, busy};
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.v) else begin
        fails++;
        $error("FAIL %s: observed %b expected %b", x.tag, obs, x.v);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    step("reset", RSTV);
    rst = 1'b0;
    step("idle", NORM);

    // Load-use on rs: one bubble, then the load has moved on.
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd5; id_rs = 5'd5; id_use = 2'b01;
    step("load_use_rs", RAW);
    ex_mem_read = 0; ex_reg_write = 0;
    step("load_use_gone", NORM);

    // rs matches but only rt is read, so there is no hazard.
    ex_mem_read = 1; ex_reg_write = 1; id_use = 2'b10; id_rt = 5'd3;
    step("unused_rs", NORM);
    id_rt = 5'd5;
    step("load_use_rt", RAW);

    // r0 never matches.
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; id_use = 2'b11;
    step("r0_load", NORM);
    clear_inputs();

    // ALU result in EX: stalls only without bypass.
    ex_reg_write = 1; ex_rd = 5'd6; id_rs = 5'd6; id_use = 2'b01;
    step("alu_ex_dep", FWD ? NORM : RAW);
    clear_inputs();

    // Producer in MEM.
    mem_reg_write = 1; mem_rd = 5'd9; id_rt = 5'd9; id_use = 2'b10;
    step("mem_dep", FWD ? NORM : RAW);
    clear_inputs();

    // Producer in WB never stalls.
    wb_reg_write = 1; wb_rd = 5'd9; id_rt = 5'd9; id_use = 2'b10;
    step("wb_dep", NORM);
    clear_inputs();

    // Forwarding selects.
    ex_rs = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1; wb_reg_write = 1;
    step("fwd_a_mem", FWD ? 11'b000_000_10_00_0 : NORM);
    mem_reg_write = 0;
    step("fwd_a_wb", FWD ? 11'b000_000_01_00_0 : NORM);
    ex_rs = 5'd0;
    step("fwd_a_r0", NORM);
    ex_rt = 5'd7; mem_reg_write = 1;
    step("fwd_b_mem", FWD ? 11'b000_000_00_10_0 : NORM);
    clear_inputs();

    // A branch overrides a load-use hazard in the same cycle.
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd5; id_rs = 5'd5; id_use = 2'b01;
    branch_taken = 1;
    step("branch_over_raw", BRCH);
    clear_inputs();

    // MDU: the start cycle is normal, then exactly 4 busy cycles.
    // A branch and a second start during busy must be ignored.
    mdu_start = 1;
    step("mdu_start", NORM);
    mdu_start = 0;
    step("mdu_busy1", MDUB);
    branch_taken = 1;
    step("mdu_busy2", MDUB);
    branch_taken = 0;
    step("mdu_busy3", MDUB);
    mdu_start = 1;
    step("mdu_busy4", MDUB);
    mdu_start = 0;
    step("mdu_done", NORM);
    step("mdu_stay_run", NORM);

    // A start coincident with a branch is dropped.
    mdu_start = 1; branch_taken = 1;
    step("mdu_vs_branch", BRCH);
    clear_inputs();
    step("mdu_dropped", NORM);

    // A reset during the second busy cycle aborts the MDU op.
    mdu_start = 1;
    step("mdu_start2", NORM);
    mdu_start = 0;
    step("mdu2_busy1", MDUB);
    rst = 1;
    step("mdu2_rst", RSTV);
    rst = 0;
    step("mdu2_abort", NORM);
    step("mdu2_stay_run", NORM);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
